serial_div_engine: RTL and testbench
====================================

SERIAL_DIV_ENGINE -- requirements
Module: serial_div_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits.
REQ-002 SHALL have parameter BUS_W, default 8, beat width in bits; WIDTH SHALL be an integer multiple of BUS_W, with NB = WIDTH/BUS_W.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic rising-edge.
REQ-004 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-005 SHALL have port push_in, input, 1, input beat strobe; a beat is accepted when push_in and in_ready are both high.
REQ-006 SHALL have port data_in, input, BUS_W, input beat.
REQ-007 SHALL have port sign, input, 1, 1 = signed division; sampled with the first dividend beat.
REQ-008 SHALL have port in_ready, output, 1, high only in state RX.
REQ-009 SHALL have port data_out, output, BUS_W, output beat.
REQ-010 SHALL have port out_valid, output, 1, data_out valid.
REQ-011 SHALL have port out_first, output, 1, high with the first output beat of a result.
REQ-012 SHALL have port out_ready, input, 1, sink accepts the beat when out_valid and out_ready are both high.
REQ-013 SHALL have port dz, output, 1, divisor was zero; held for the whole TX phase.

Function
REQ-014 SHALL implement FSM states RX, CALC, FIX and TX.
REQ-015 RX SHALL accept 2*NB beats, MSB beat first: dividend A first, then divisor B; a beat counter tracks them.
REQ-016 push_in while in_ready is low SHALL be ignored, with no state change.
REQ-017 On the last B beat: if B==0 the FSM SHALL go to FIX, else to CALC.
REQ-018 CALC SHALL run restoring radix-2 on magnitudes, one quotient bit per cycle, for exactly WIDTH cycles, then go to FIX.
REQ-019 Magnitudes: in signed mode, |x| of each operand; in unsigned mode, the raw value. The datapath is WIDTH+1 bits wide so that |MIN| is representable.
REQ-020 FIX (1 cycle) SHALL apply signs: Q negated if sign(A)^sign(B); R takes the sign of A (truncating division).
REQ-021 Divide by zero SHALL give Q = all ones and R = A, with dz=1; this applies in both modes.
REQ-022 Signed MIN / -1 SHALL give Q = MIN, R = 0, with dz=0.
REQ-023 TX SHALL emit 2*NB beats of {Q,R}, least-significant beat first: R beats first, then Q beats.
REQ-024 Each TX beat SHALL advance only on out_valid&&out_ready; data_out SHALL be held stable while out_ready is low.
REQ-025 After the last TX beat is accepted, the FSM SHALL return to RX in the next cycle and clear dz.
REQ-026 Latency, with the last input beat accepted at cycle t: first out_valid at t+WIDTH+2 when B!=0; at t+2 when B==0.
REQ-027 The RX beat counter and the TX beat counter SHALL each wrap to 0 at the end of their phase; no partial state SHALL carry over between operations.

Reset
REQ-028 While rst is high, state SHALL be RX and all counters 0.
REQ-029 While rst is high, data_out, out_valid, out_first and dz SHALL be 0, and in_ready SHALL be 1 from the cycle after rst is sampled.
REQ-030 rst asserted in any state, including mid-CALC and mid-TX, SHALL abort the operation and discard all partial operands and results.

Structure
REQ-031 Shared package serial_div_pkg SHALL hold the FSM state enum and the default WIDTH/BUS_W constants.
REQ-032 One sub-module, udiv_radix2, SHALL hold the unsigned iterative shift/subtract datapath: start, WIDTH-cycle run, done, q, r.
REQ-033 Beat counters, sign handling and FIX/TX muxing SHALL live in serial_div_engine.

Verification (WIDTH=32, BUS_W=8)
REQ-034 Unsigned test: sign=0, in 00 00 00 64 / 00 00 00 07 -> out 02 00 00 00 0E 00 00 00, out_first on beat 1, first valid at t+34.
REQ-035 Signed test: sign=1, FFFFFFF9 / 00000002 -> R=FFFFFFFF, Q=FFFFFFFD, dz=0.
REQ-036 Divide-by-zero test: 12345678 / 00000000, both modes -> R=12345678, Q=FFFFFFFF, dz=1, first valid at t+2.
REQ-037 Overflow test: sign=1, 80000000 / FFFFFFFF -> Q=80000000, R=00000000.
REQ-038 Backpressure test: out_ready low 3 cycles on beat 4, with push_in pulsed during TX -> beat 4 held stable, no beat lost or duplicated, push ignored, in_ready=0.
REQ-039 Reset test: rst pulse mid-CALC -> next cycle out_valid=0 and in_ready=1; the following 100/7 yields Q=14, R=2.

Source files
------------

// File: rtl/serial_div_pkg.sv
// Shared types and default sizing for the serial divider engine.
package serial_div_pkg;
  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned BUS_W_DEF = 8;

  typedef enum logic [1:0] {
    RX   = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    TX   = 2'd3
  } state_t;
endpackage

// File: rtl/udiv_radix2.sv
// Unsigned restoring radix-2 divider; the first step happens on the start edge,
// so the WIDTH-th step completes WIDTH-1 cycles later and done pulses after it.
module udiv_radix2 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  logic [CNT_W-1:0] cnt;
  logic             busy;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] quo_cur, rem_cur, div_cur, quo_nx, rem_nx;
  logic [WIDTH:0]   rem_sh, div_ext;
  logic             take;

  // One shift/subtract step, seeded from the operands on start.
  always_comb begin
    quo_cur = start ? a : q;
    rem_cur = start ? '0 : r;
    div_cur = start ? b : d;
    div_ext = {1'b0, div_cur};
    rem_sh  = {rem_cur, quo_cur[WIDTH-1]};
    take    = (rem_sh >= div_ext);
    rem_nx  = take ? WIDTH'(rem_sh - div_ext) : rem_sh[WIDTH-1:0];
    quo_nx  = {quo_cur[WIDTH-2:0], take};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      d    <= '0;
      q    <= '0;
      r    <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        q    <= quo_nx;
        r    <= rem_nx;
        d    <= b;
        cnt  <= CNT_W'(1);
        busy <= 1'b1;
      end else if (busy) begin
        q   <= quo_nx;
        r   <= rem_nx;
        cnt <= cnt + CNT_W'(1);
        if (cnt == CNT_W'(WIDTH - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
          cnt  <= '0;
        end
      end
    end
  end
endmodule

// File: rtl/serial_div_engine.sv
// Beat-serial signed/unsigned divider: receives A then B MSB beat first,
// returns {Q,R} least-significant beat first.
module serial_div_engine
  import serial_div_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned BUS_W = BUS_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_in,
  input  logic [BUS_W-1:0] data_in,
  input  logic             sign,
  output logic             in_ready,
  output logic [BUS_W-1:0] data_out,
  output logic             out_valid,
  output logic             out_first,
  input  logic             out_ready,
  output logic             dz
);
  localparam int unsigned NB    = WIDTH / BUS_W;
  localparam int unsigned BEATS = 2 * NB;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  state_t state, state_n;
  logic [CNT_W-1:0]         rx_cnt, tx_cnt;
  logic [2*WIDTH-1:0]       opnd, opnd_nx, fix_all;
  logic [2*WIDTH-BUS_W-1:0] res_q;
  logic [WIDTH-1:0]         a_full, b_full, a_mag, b_mag, a_raw_q;
  logic [WIDTH-1:0]         div_q, div_r, q_fix, r_fix;
  logic sign_q, a_neg_q, b_neg_q, zero_q;
  logic accept, rx_last, tx_fire, tx_last, a_neg, b_neg, b_zero, div_start, div_done;

  always_comb begin
    accept    = push_in && in_ready;
    rx_last   = (rx_cnt == CNT_W'(BEATS - 1));
    tx_fire   = out_valid && out_ready;
    tx_last   = (tx_cnt == CNT_W'(BEATS - 1));
    opnd_nx   = {opnd[2*WIDTH-BUS_W-1:0], data_in};
    a_full    = opnd_nx[2*WIDTH-1:WIDTH];
    b_full    = opnd_nx[WIDTH-1:0];
    a_neg     = sign_q && a_full[WIDTH-1];
    b_neg     = sign_q && b_full[WIDTH-1];
    a_mag     = a_neg ? -a_full : a_full;
    b_mag     = b_neg ? -b_full : b_full;
    b_zero    = (b_full == '0);
    div_start = accept && rx_last && !b_zero;
    // Sign fix-up; divide-by-zero overrides with all-ones / raw dividend.
    q_fix     = zero_q ? '1 : ((a_neg_q ^ b_neg_q) ? -div_q : div_q);
    r_fix     = zero_q ? a_raw_q : (a_neg_q ? -div_r : div_r);
    fix_all   = {q_fix, r_fix};
  end

  udiv_radix2 #(.WIDTH(WIDTH)) u_div (
    .clk   (clk),
    .rst   (rst),
    .start (div_start),
    .a     (a_mag),
    .b     (b_mag),
    .done  (div_done),
    .q     (div_q),
    .r     (div_r)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= RX;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      RX:   if (accept && rx_last) state_n = b_zero ? FIX : CALC;
      CALC: if (div_done) state_n = FIX;
      FIX:  state_n = TX;
      TX:   if (tx_fire && tx_last) state_n = RX;
      default: state_n = RX;
    endcase
  end

  // Operand capture, beat counters and result shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_cnt  <= '0;
      tx_cnt  <= '0;
      opnd    <= '0;
      sign_q  <= 1'b0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      zero_q  <= 1'b0;
      a_raw_q <= '0;
      res_q   <= '0;
    end else begin
      if (accept) begin
        opnd   <= rx_last ? '0 : opnd_nx;
        rx_cnt <= rx_last ? '0 : rx_cnt + CNT_W'(1);
        if (rx_cnt == '0) sign_q <= sign;
        if (rx_last) begin
          a_neg_q <= a_neg;
          b_neg_q <= b_neg;
          zero_q  <= b_zero;
          a_raw_q <= a_full;
        end
      end
      if (state == FIX) begin
        res_q <= fix_all[2*WIDTH-1:BUS_W];
      end else if (tx_fire) begin
        res_q  <= res_q >> BUS_W;
        tx_cnt <= tx_last ? '0 : tx_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b1;
      data_out  <= '0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      dz        <= 1'b0;
    end else begin
      in_ready <= (state_n == RX);
      if (state == FIX) begin
        out_valid <= 1'b1;
        out_first <= 1'b1;
        data_out  <= fix_all[BUS_W-1:0];
        dz        <= zero_q;
      end else if (tx_fire) begin
        out_first <= 1'b0;
        if (tx_last) begin
          out_valid <= 1'b0;
          data_out  <= '0;
          dz        <= 1'b0;
        end else begin
          data_out <= res_q[BUS_W-1:0];
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_div_engine.sv
// Directed self-checking bench for serial_div_engine at WIDTH=32, BUS_W=8.
module tb_serial_div_engine;
  logic       clk = 1'b0;
  logic       rst, push_in, sign, out_ready;
  logic [7:0] data_in;
  logic       in_ready, out_valid, out_first, dz;
  logic [7:0] data_out;
  int checks = 0;
  int failures = 0;

  serial_div_engine #(.WIDTH(32), .BUS_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .push_in   (push_in),
    .data_in   (data_in),
    .sign      (sign),
    .in_ready  (in_ready),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_first (out_first),
    .out_ready (out_ready),
    .dz        (dz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives 8 beats {A,B} MSB first; returns just after the edge taking the last beat.
  task automatic send(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] v;
    v = {a, b};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rx_in_ready", 64'(in_ready), 64'd1);
      push_in = 1'b1;
      sign    = s;
      data_in = v[63-8*i -: 8];
      @(posedge clk);
    end
  endtask

  // Edges after the last-input edge until out_valid is seen (33 => cycle t+34, 1 => t+2).
  task automatic wait_valid(output int lat);
    lat = 0;
    forever begin
      @(negedge clk);
      push_in = 1'b0;
      if (out_valid || lat >= 100) break;
      lat++;
    end
  endtask

  // Collects 8 beats from the current negedge; optional 3-cycle stall on one beat.
  task automatic recv(input int stall_beat, input logic exp_dz, output logic [63:0] res);
    int n, guard, stalls;
    logic [7:0] held;
    n = 0; guard = 0; stalls = 0; held = '0; res = '0;
    while (n < 8 && guard < 200) begin
      if (out_valid) begin
        if (n == stall_beat && stalls < 3) begin
          out_ready = 1'b0;
          push_in   = 1'b1;
          data_in   = 8'hAA;
          if (stalls == 0) held = data_out;
          else check("stall_hold", 64'(data_out), 64'(held));
          check("stall_in_ready", 64'(in_ready), 64'd0);
          stalls++;
        end else begin
          out_ready = 1'b1;
          push_in   = 1'b0;
          if (n == stall_beat) check("stall_release", 64'(data_out), 64'(held));
          res[8*n +: 8] = data_out;
          check("out_first", 64'(out_first), 64'(n == 0));
          check("dz_tx", 64'(dz), 64'(exp_dz));
          n++;
        end
      end
      @(negedge clk);
      guard++;
    end
    push_in = 1'b0;
    check("recv_beats", 64'(n), 64'd8);
    check("post_valid", 64'(out_valid), 64'd0);
    check("post_in_ready", 64'(in_ready), 64'd1);
    check("post_dz", 64'(dz), 64'd0);
  endtask

  task automatic run_op(input string tag, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic exp_dz,
                        input logic [63:0] exp_res, input int stall_beat);
    int lat;
    logic [63:0] res;
    send(s, a, b);
    wait_valid(lat);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    recv(stall_beat, exp_dz, res);
    check({tag, "_res"}, res, exp_res);
  endtask

  initial begin
    rst = 1'b1; push_in = 1'b0; sign = 1'b0; data_in = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_first", 64'(out_first), 64'd0);
    check("rst_data", 64'(data_out), 64'd0);
    check("rst_dz", 64'(dz), 64'd0);
    rst = 1'b0;

    // Result packed as {Q,R}; beat n lands in bits [8n+7:8n].
    run_op("u100_7",   1'b0, 32'd100,        32'd7,          33, 1'b0, {32'h0000000E, 32'h00000002}, -1);
    run_op("s_m7_2",   1'b1, 32'hFFFFFFF9,   32'h00000002,   33, 1'b0, {32'hFFFFFFFD, 32'hFFFFFFFF}, -1);
    run_op("u_big_2",  1'b0, 32'hFFFFFFF9,   32'h00000002,   33, 1'b0, {32'h7FFFFFFC, 32'h00000001}, -1);
    run_op("s100_m7",  1'b1, 32'd100,        32'hFFFFFFF9,   33, 1'b0, {32'hFFFFFFF2, 32'h00000002}, -1);
    run_op("s_m100_7", 1'b1, 32'hFFFFFF9C,   32'd7,          33, 1'b0, {32'hFFFFFFF2, 32'hFFFFFFFE}, -1);
    run_op("dz_u",     1'b0, 32'h12345678,   32'h00000000,   1,  1'b1, {32'hFFFFFFFF, 32'h12345678}, -1);
    run_op("dz_s",     1'b1, 32'h12345678,   32'h00000000,   1,  1'b1, {32'hFFFFFFFF, 32'h12345678}, -1);
    run_op("ovf",      1'b1, 32'h80000000,   32'hFFFFFFFF,   33, 1'b0, {32'h80000000, 32'h00000000}, -1);
    run_op("bp",       1'b0, 32'd100,        32'd7,          33, 1'b0, {32'h0000000E, 32'h00000002}, 3);

    // Abort mid-CALC with a one-cycle reset pulse.
    send(1'b0, 32'd1000, 32'd3);
    repeat (10) begin
      @(negedge clk);
      push_in = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_valid", 64'(out_valid), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    run_op("after_rst", 1'b0, 32'd100, 32'd7, 33, 1'b0, {32'h0000000E, 32'h00000002}, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
